// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with one shared counter and shadowed duty codes.
// The counter runs edge-aligned (saw-tooth) or centre-aligned (triangle).
// Duty codes and the mode are sampled only at the period boundary, so a
// period never mixes old and new settings.
// CBITS must be at least DBITS+2.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   en           counter/output enable; low forces idle and makes the shadows transparent
//   center       0 edge-aligned, 1 centre-aligned (sampled at period boundary)
//   duty         NCH duty codes, channel i at [i*DBITS +: DBITS]
//   pwm_out      per-channel PWM outputs (registered)
//   lb_pulse     reference pulse for duty code 0 (registered)
//   ub_pulse     reference pulse for duty code all-ones (registered)
//   period_tick  one-cycle strobe marking the start of a period (registered)
module pwm_multi #(
  parameter int unsigned CBITS = 11,
  parameter int unsigned DBITS = 4,
  parameter int unsigned NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 center,
  input  logic [NCH*DBITS-1:0] duty,
  output logic [NCH-1:0]       pwm_out,
  output logic                 lb_pulse,
  output logic                 ub_pulse,
  output logic                 period_tick
);

  localparam int unsigned      SH      = CBITS - DBITS - 2;
  localparam logic [CBITS-1:0] CNT_MAX = {CBITS{1'b1}};
  localparam logic [CBITS-1:0] CNT_ONE = CBITS'(1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  // Threshold is {0, code, 1, zeros}: the trailing 1 keeps code 0 non-empty
  // and code all-ones short of full scale.
  function automatic logic [CBITS-1:0] thr_f(input logic [DBITS-1:0] d);
    return CBITS'({d, 1'b1}) << SH;
  endfunction

  localparam logic [CBITS-1:0] THR_LB = thr_f({DBITS{1'b0}});
  localparam logic [CBITS-1:0] THR_UB = thr_f({DBITS{1'b1}});

  logic [CBITS-1:0]     cnt_q, cnt_d;
  dir_e                 dir_q, dir_d;
  logic [NCH*DBITS-1:0] duty_sh_q, duty_sh_d;
  logic                 mode_sh_q, mode_sh_d;
  logic [NCH-1:0]       pwm_out_q, pwm_out_d;
  logic                 lb_pulse_q, lb_pulse_d;
  logic                 ub_pulse_q, ub_pulse_d;
  logic                 period_tick_q, period_tick_d;
  logic                 boundary_c;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      dir_q         <= DIR_UP;
      duty_sh_q     <= '0;
      mode_sh_q     <= 1'b0;
      pwm_out_q     <= '0;
      lb_pulse_q    <= 1'b0;
      ub_pulse_q    <= 1'b0;
      period_tick_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      duty_sh_q     <= duty_sh_d;
      mode_sh_q     <= mode_sh_d;
      pwm_out_q     <= pwm_out_d;
      lb_pulse_q    <= lb_pulse_d;
      ub_pulse_q    <= ub_pulse_d;
      period_tick_q <= period_tick_d;
    end
  end

  // Counter sequencing, shadow reload and compare outputs
  always_comb begin
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    duty_sh_d     = duty_sh_q;
    mode_sh_d     = mode_sh_q;
    pwm_out_d     = '0;
    lb_pulse_d    = 1'b0;
    ub_pulse_d    = 1'b0;
    period_tick_d = 1'b0;

    // Next count is 0: end of saw-tooth, or bottom of the triangle's down slope
    boundary_c = mode_sh_q ? ((dir_q == DIR_DOWN) && (cnt_q == CNT_ONE))
                           : (cnt_q == CNT_MAX);

    if (!en) begin
      cnt_d     = '0;
      dir_d     = DIR_UP;
      duty_sh_d = duty;
      mode_sh_d = center;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        pwm_out_d[i] = (cnt_q < thr_f(duty_sh_q[i*DBITS +: DBITS]));
      end
      lb_pulse_d = (cnt_q < THR_LB);
      ub_pulse_d = (cnt_q < THR_UB);

      if (boundary_c) begin
        cnt_d         = '0;
        dir_d         = DIR_UP;
        duty_sh_d     = duty;
        mode_sh_d     = center;
        period_tick_d = 1'b1;
      end else if (mode_sh_q && (dir_q == DIR_DOWN)) begin
        cnt_d = cnt_q - CNT_ONE;
      end else if (mode_sh_q && (cnt_q == CNT_MAX)) begin
        // Top of the triangle: turn around without repeating MAX
        cnt_d = CNT_MAX - CNT_ONE;
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  assign pwm_out     = pwm_out_q;
  assign lb_pulse    = lb_pulse_q;
  assign ub_pulse    = ub_pulse_q;
  assign period_tick = period_tick_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi (CBITS=11, DBITS=4, NCH=4).
module tb_pwm_multi;

  localparam int unsigned CBITS = 11;
  localparam int unsigned DBITS = 4;
  localparam int unsigned NCH   = 4;

  logic                 clk    = 1'b0;
  logic                 rst_n  = 1'b1;
  logic                 en     = 1'b0;
  logic                 center = 1'b0;
  logic [NCH*DBITS-1:0] duty   = '0;
  logic [NCH-1:0]       pwm_out;
  logic                 lb_pulse;
  logic                 ub_pulse;
  logic                 period_tick;

  pwm_multi #(.CBITS(CBITS), .DBITS(DBITS), .NCH(NCH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .center      (center),
    .duty        (duty),
    .pwm_out     (pwm_out),
    .lb_pulse    (lb_pulse),
    .ub_pulse    (ub_pulse),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  int         r_hi [NCH];
  int         r_lb, r_ub, r_ticks, r_tick_idx, r_inv;
  logic [5:0] r_first;

  typedef struct {
    logic        center;
    logic [15:0] duty;
    int          p;
    int          e0, e1, e2, e3, elb, eub;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_now();
    return int'({period_tick, ub_pulse, lb_pulse, pwm_out});
  endfunction

  // Sample n cycles at the falling edge; optionally change inputs after sample chg_at
  task automatic run_samples(input int n, input int chg_at,
                             input logic [15:0] nduty, input logic ncenter);
    for (int c = 0; c < NCH; c++) r_hi[c] = 0;
    r_lb = 0; r_ub = 0; r_ticks = 0; r_tick_idx = 0; r_inv = 0; r_first = '0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 1) r_first = {ub_pulse, lb_pulse, pwm_out};
      for (int c = 0; c < NCH; c++) begin
        if (pwm_out[c]) r_hi[c]++;
        if (lb_pulse && !pwm_out[c]) r_inv++;
        if (pwm_out[c] && !ub_pulse) r_inv++;
      end
      if (lb_pulse) r_lb++;
      if (ub_pulse) r_ub++;
      if (period_tick) begin
        r_ticks++;
        r_tick_idx = i;
      end
      if (i == chg_at) begin
        duty   = nduty;
        center = ncenter;
      end
    end
  endtask

  task automatic check_period(input string tag, input int p,
                              input int e0, input int e1, input int e2, input int e3,
                              input int elb, input int eub);
    check($sformatf("%s_hi0", tag), r_hi[0], e0);
    check($sformatf("%s_hi1", tag), r_hi[1], e1);
    check($sformatf("%s_hi2", tag), r_hi[2], e2);
    check($sformatf("%s_hi3", tag), r_hi[3], e3);
    check($sformatf("%s_lb", tag), r_lb, elb);
    check($sformatf("%s_ub", tag), r_ub, eub);
    check($sformatf("%s_ticks", tag), r_ticks, 1);
    check($sformatf("%s_tick_idx", tag), r_tick_idx, p);
    check($sformatf("%s_invariant", tag), r_inv, 0);
    check($sformatf("%s_first", tag), int'(r_first), 'h3F);
  endtask

  // Disable, load new settings through the transparent shadow, then enable
  task automatic idle_load(input string tag, input logic [15:0] d, input logic c);
    en     = 1'b0;
    duty   = d;
    center = c;
    @(negedge clk);
    @(negedge clk);
    check($sformatf("%s_idle", tag), outs_now(), 0);
    en = 1'b1;
  endtask

  int idle_bad;

  initial begin
    vecs[0] = '{1'b0, 16'h8F05, 2048,  352,   32,  992,  544, 32,  992};
    vecs[1] = '{1'b1, 16'h8F05, 4094,  703,   63, 1983, 1087, 63, 1983};
    vecs[2] = '{1'b0, 16'hE321, 2048,   96,  160,  224,  928, 32,  992};
    vecs[3] = '{1'b1, 16'hE321, 4094,  191,  319,  447, 1855, 63, 1983};

    // Power-on reset
    #1 rst_n = 1'b0;
    #1 check("por_outputs", outs_now(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one full period per vector
    for (int v = 0; v < 4; v++) begin
      idle_load($sformatf("vec%0d", v), vecs[v].duty, vecs[v].center);
      run_samples(vecs[v].p, 0, vecs[v].duty, vecs[v].center);
      check_period($sformatf("vec%0d", v), vecs[v].p, vecs[v].e0, vecs[v].e1,
                   vecs[v].e2, vecs[v].e3, vecs[v].elb, vecs[v].eub);
    end

    // Asynchronous reset between edges mid-period
    idle_load("rst", 16'h8F05, 1'b0);
    run_samples(10, 0, 16'h8F05, 1'b0);
    check("rst_pre_outputs", outs_now(), 'h3F);
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", outs_now(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Reset cleared the shadows, so this period runs on duty code 0
    run_samples(2048, 0, 16'h8F05, 1'b0);
    check_period("rst_after", 2048, 32, 32, 32, 32, 32, 992);
    run_samples(2048, 0, 16'h8F05, 1'b0);
    check_period("rst_reload", 2048, 352, 32, 992, 544, 32, 992);

    // Mid-period duty change on ch1 (0 -> 15) waits for the boundary
    run_samples(2048, 501, 16'h8FF5, 1'b0);
    check_period("duty_cur", 2048, 352, 32, 992, 544, 32, 992);
    run_samples(2048, 0, 16'h8FF5, 1'b0);
    check_period("duty_next", 2048, 352, 992, 992, 544, 32, 992);

    // Mid-period switch to centre mode takes effect after the wrap
    run_samples(2048, 700, 16'h8FF5, 1'b1);
    check_period("mode_cur", 2048, 352, 992, 992, 544, 32, 992);
    run_samples(4094, 0, 16'h8FF5, 1'b1);
    check_period("mode_next", 4094, 703, 1983, 1983, 1087, 63, 1983);

    // Enable dropped mid-period for 10 cycles
    run_samples(700, 0, 16'h8FF5, 1'b1);
    check("en_pre_invariant", r_inv, 0);
    en = 1'b0;
    idle_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) check("en_low_first", outs_now(), 0);
      if (outs_now() != 0) idle_bad++;
    end
    check("en_low_idle", idle_bad, 0);
    en = 1'b1;
    run_samples(4094, 0, 16'h8FF5, 1'b1);
    check_period("en_restart", 4094, 703, 1983, 1983, 1087, 63, 1983);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
